// File: rtl/user_code_mem.sv
`default_nettype none
// ============================================================================
// Module   : user_code_mem
// Purpose  : Writable instruction store with a registered fetch port and a
//            streaming program loader that tracks a running word checksum.
// Revision : 1.0 - initial release
// ============================================================================
module user_code_mem #(
  parameter int WORD_W = 17,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_abort,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [WORD_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [WORD_W-1:0]   r_rd_data;
  logic [WORD_W-1:0]   r_checksum;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_remaining;
  logic                r_err;
  logic                w_len_ok;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_accept;
  logic                w_abort;

  assign w_len_ok = (ld_len != '0) && (ld_len <= c_depth);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    ld_ready    = 1'b0;
    ld_busy     = 1'b1;
    ld_done     = 1'b0;
    case (r_state)
      IDLE: begin
        ld_busy = 1'b0;
        if (ld_start) begin
          if (w_len_ok) begin
            w_start_ok = 1'b1;
            w_next     = LOAD;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        // Abort takes priority over a word offered on the same edge.
        if (ld_abort) begin
          w_abort = 1'b1;
          w_next  = IDLE;
        end else if (ld_valid) begin
          w_accept = 1'b1;
          if (r_remaining == (ADDR_W+1)'(1)) begin
            w_next = DONE;
          end
        end
      end
      DONE: begin
        ld_done = 1'b1;
        w_next  = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_checksum  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_start_bad | w_abort;
      if (w_start_ok) begin
        r_ptr       <= ld_base;
        r_remaining <= ld_len;
        r_checksum  <= '0;
      end else if (w_accept) begin
        r_ptr       <= r_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - (ADDR_W+1)'(1);
        r_checksum  <= r_checksum + ld_data;
      end
    end
  end

  // Read samples the array before this edge's write, giving read-before-write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (rd_en) begin
        r_rd_data <= r_mem[rd_addr];
      end
      if (w_accept) begin
        r_mem[r_ptr] <= ld_data;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign checksum = r_checksum;
  assign ld_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_user_code_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_user_code_mem
// Purpose  : Randomized scoreboard bench for user_code_mem against an
//            array-based reference of memory contents and checksum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_user_code_mem;

  localparam int WORD_W = 17;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [WORD_W-1:0] ld_data;
  logic              ld_abort;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              ld_err;
  logic [WORD_W-1:0] checksum;

  user_code_mem #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_abort(ld_abort),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_err(ld_err), .checksum(checksum)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit                is_done;
    logic [WORD_W-1:0] sum;
  } ev_t;

  int                tests = 0;
  int                fails = 0;
  logic [WORD_W-1:0] m_mem [DEPTH];
  logic [WORD_W-1:0] m_sum;
  logic [WORD_W-1:0] rd_q [$];
  ev_t               ev_q [$];
  logic [WORD_W-1:0] pat_q [$];
  logic              rd_fire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: any registered read or completion/error pulse is matched
  // against the oldest expectation queued by the stimulus.
  always @(posedge clock or posedge reset) begin
    if (reset) rd_fire <= 1'b0;
    else       rd_fire <= rd_en;
  end

  always @(negedge clock) begin
    ev_t e;
    if (!reset) begin
      if (rd_fire) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else                  check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      end
      if (ld_done || ld_err) begin
        if (ev_q.size() == 0) begin
          check("event_unexpected", {30'd0, ld_done, ld_err}, 32'd0);
        end else begin
          e = ev_q.pop_front();
          check("event_kind", {30'd0, ld_done, ld_err}, e.is_done ? 32'd2 : 32'd1);
          check("event_sum", 32'(checksum), 32'(e.sum));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic maybe_read();
    rd_en   = 1'($urandom_range(0, 1));
    rd_addr = ADDR_W'($urandom);
    if (rd_en) rd_q.push_back(m_mem[rd_addr]);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(a);
      rd_q.push_back(m_mem[a]);
      tick();
    end
    rd_en = 1'b0;
    tick();
  endtask

  // abort_at < 0 runs the load to completion.
  task automatic load(input int base, input int len, input int abort_at);
    int acc = 0;
    int ptr = base;
    bit legal = (len >= 1) && (len <= DEPTH);
    bit aborted = 0;
    maybe_read();
    ld_start = 1'b1;
    ld_base  = ADDR_W'(base);
    ld_len   = (ADDR_W+1)'(len);
    ld_valid = 1'($urandom_range(0, 1));
    ld_data  = WORD_W'($urandom);
    if (!legal) ev_q.push_back('{1'b0, m_sum});
    else        m_sum = '0;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    rd_en    = 1'b0;
    if (!legal) begin
      tick();
      check("busy_after_bad_start", {31'd0, ld_busy}, 32'd0);
      check("sum_after_bad_start", 32'(checksum), 32'(m_sum));
      return;
    end
    check("ready_in_load", {31'd0, ld_ready}, 32'd1);
    check("busy_in_load", {31'd0, ld_busy}, 32'd1);
    for (int cyc = 0; cyc < 400 && acc < len; cyc++) begin
      maybe_read();
      ld_start = ($urandom_range(0, 7) == 0);
      ld_len   = '0;
      if (acc == abort_at) begin
        ld_abort = 1'b1;
        ld_valid = 1'b1;
        ld_data  = WORD_W'($urandom);
        ev_q.push_back('{1'b0, m_sum});
        tick();
        ld_abort = 1'b0;
        aborted  = 1;
        break;
      end
      ld_valid = ($urandom_range(0, 3) != 0);
      if (ld_valid) begin
        ld_data = (pat_q.size() > 0) ? pat_q.pop_front() : WORD_W'($urandom);
        m_mem[ptr] = ld_data;
        m_sum      = m_sum + ld_data;
        ptr        = (ptr + 1) % DEPTH;
        acc++;
        if (acc == len) ev_q.push_back('{1'b1, m_sum});
      end
      tick();
    end
    if (!aborted && acc < len) check("load_cycle_budget", 32'(acc), 32'(len));
    ld_start = 1'b0;
    maybe_read();
    ld_valid = 1'($urandom_range(0, 1));
    ld_data  = WORD_W'($urandom);
    tick();
    ld_valid = 1'b0;
    ld_abort = 1'($urandom_range(0, 1));
    rd_en    = 1'b0;
    tick();
    ld_abort = 1'b0;
    check("idle_after_load", {31'd0, ld_busy}, 32'd0);
    check("sum_hold", 32'(checksum), 32'(m_sum));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
    check({tag, "_ready"}, {31'd0, ld_ready}, 32'd0);
    check({tag, "_busy"}, {31'd0, ld_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, ld_done}, 32'd0);
    check({tag, "_err"}, {31'd0, ld_err}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rd_en    = 1'b0;
    rd_addr  = '0;
    ld_start = 1'b0;
    ld_base  = '0;
    ld_len   = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_sum = '0;
    #12;
    check_all_zero("reset");
    tick();
    reset = 1'b0;

    rd_en   = 1'b1;
    rd_addr = 4'd5;
    rd_q.push_back(m_mem[5]);
    tick();
    rd_en = 1'b0;
    tick();

    pat_q = '{17'h06308, 17'h01A00, 17'h00001};
    load(0, 3, -1);
    check("sum_known_program", 32'(checksum), 32'h07D09);
    read_all();

    load(14, 4, -1);
    read_all();

    load(3, 5, 2);
    read_all();

    load(0, 0, -1);
    load(0, 17, -1);

    for (int n = 0; n < 25; n++) begin
      int len = $urandom_range(1, DEPTH);
      int r   = $urandom_range(0, 9);
      if (r == 0)      load($urandom_range(0, DEPTH-1), (len == 1) ? 0 : DEPTH + 1, -1);
      else if (r < 4)  load($urandom_range(0, DEPTH-1), len, $urandom_range(0, len-1));
      else             load($urandom_range(0, DEPTH-1), len, -1);
      if (n % 6 == 5) read_all();
    end
    read_all();

    // Stall with ld_valid low, then reset in the middle of the load.
    ld_start = 1'b1;
    ld_base  = 4'd6;
    ld_len   = 5'd4;
    m_sum    = '0;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = WORD_W'($urandom);
    m_mem[6] = ld_data;
    tick();
    ld_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ld_data = WORD_W'($urandom);
      rd_en   = 1'b1;
      rd_addr = 4'd7;
      rd_q.push_back(m_mem[7]);
      tick();
    end
    rd_en = 1'b0;
    tick();
    check("rd_mid_stall", 32'(rd_data), 32'(m_mem[7]));
    reset = 1'b1;
    #2;
    check_all_zero("midload_reset");
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_sum = '0;
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("after_reset");
    read_all();
    load(9, 2, -1);
    read_all();

    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("event_queue_drained", 32'(ev_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
